// File: rtl/kan_tda_stream_pkg.sv
// Shared constants, derivations and types for the KAN/TDA result streamer.
// Holds the default geometry, the beats-per-frame / beat-counter derivation,
// the lane-packing width helper and the streaming FSM state type.
package kan_tda_stream_pkg;

  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefNumWords     = 256;
  localparam int unsigned DefLanes        = 4;
  localparam int unsigned DefFrameIdWidth = 8;
  localparam int unsigned DefDropCntWidth = 16;

  // Number of output beats needed to carry one frame.
  function automatic int unsigned beats_per_frame(int unsigned num_words, int unsigned lanes);
    return num_words / lanes;
  endfunction

  // Beat counter width; kept at least 1 bit so a single-beat frame still elaborates.
  function automatic int unsigned beat_cnt_width(int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Lane packing: lane j of a beat sits at [j*DATA_WIDTH +: DATA_WIDTH].
  function automatic int unsigned beat_width(int unsigned data_width, int unsigned lanes);
    return data_width * lanes;
  endfunction

  localparam int unsigned BEATS_PER_FRAME = beats_per_frame(DefNumWords, DefLanes);
  localparam int unsigned BEAT_CNT_WIDTH  = beat_cnt_width(BEATS_PER_FRAME);
  localparam int unsigned DEF_BEAT_WIDTH  = beat_width(DefDataWidth, DefLanes);

  typedef enum logic {
    StIdle,
    StStream
  } stream_state_e;

endpackage

// File: rtl/kan_tda_result_streamer_if.sv
// Output stream interface of the result streamer.
//   m_data     : beat payload (LANES words)
//   m_valid    : beat valid
//   m_ready    : sink ready
//   m_sof      : first beat of a frame
//   m_eof      : last beat of a frame
//   m_frame_id : sequence number of the frame being streamed
interface kan_tda_result_streamer_if
  import kan_tda_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_BEAT_WIDTH,
  parameter int unsigned ID_W   = DefFrameIdWidth
) ();

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eof;
  logic [ID_W-1:0]   m_frame_id;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready,
    output m_sof,
    output m_eof,
    output m_frame_id
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_sof,
    input  m_eof,
    input  m_frame_id
  );

endinterface

// File: rtl/result_bank.sv
// One frame buffer of the ping-pong pair.
//   clk, rst   : clock, synchronous active-high reset (clears valid flag and tag)
//   wr_en_i    : copy wr_data_i into the bank in one cycle and mark it valid
//   wr_data_i  : full flattened frame
//   wr_id_i    : frame-id tag stored with the frame
//   clr_i      : release the bank (frame fully drained)
//   rd_beat_i  : beat index to read
//   rd_data_o  : LANES words of the selected beat
//   valid_o    : bank holds a frame not yet fully drained
//   id_o       : frame-id tag of the stored frame
module result_bank
  import kan_tda_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned NUM_WORDS      = DefNumWords,
  parameter int unsigned LANES          = DefLanes,
  parameter int unsigned FRAME_ID_WIDTH = DefFrameIdWidth,
  parameter int unsigned CNT_WIDTH      = BEAT_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] wr_data_i,
  input  logic [FRAME_ID_WIDTH-1:0]       wr_id_i,
  input  logic                            clr_i,
  input  logic [CNT_WIDTH-1:0]            rd_beat_i,
  output logic [LANES*DATA_WIDTH-1:0]     rd_data_o,
  output logic                            valid_o,
  output logic [FRAME_ID_WIDTH-1:0]       id_o
);

  localparam int unsigned BeatW = beat_width(DATA_WIDTH, LANES);

  logic [NUM_WORDS*DATA_WIDTH-1:0] mem_q;
  logic                            valid_q;
  logic [FRAME_ID_WIDTH-1:0]       id_q;

  // Payload needs no reset: it is only ever read while valid_q is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      id_q    <= wr_id_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign rd_data_o = mem_q[int'(rd_beat_i) * BeatW +: BeatW];
  assign valid_o   = valid_q;
  assign id_o      = id_q;

endmodule

// File: rtl/kan_tda_result_streamer.sv
// Captures result frames from the compute core into two ping-pong banks and
// drains them, oldest first, as a valid/ready stream of LANES-word beats.
//   clk, rst         : clock, synchronous active-high reset
//   result_data_i    : flattened result bank, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   result_valid_i   : single-cycle frame-available strobe
//   capture_ready_o  : registered, high while at least one bank is free
//   frames_dropped_o : saturating count of frames rejected for lack of a bank
//   m_if             : output stream (data, valid, ready, sof, eof, frame id)
module kan_tda_result_streamer
  import kan_tda_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned NUM_WORDS      = DefNumWords,
  parameter int unsigned LANES          = DefLanes,
  parameter int unsigned FRAME_ID_WIDTH = DefFrameIdWidth,
  parameter int unsigned DROP_CNT_WIDTH = DefDropCntWidth
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] result_data_i,
  input  logic                            result_valid_i,
  output logic                            capture_ready_o,
  output logic [DROP_CNT_WIDTH-1:0]       frames_dropped_o,
  kan_tda_result_streamer_if.master       m_if
);

  localparam int unsigned BeatW = beat_width(DATA_WIDTH, LANES);
  localparam int unsigned Beats = beats_per_frame(NUM_WORDS, LANES);
  localparam int unsigned CntW  = beat_cnt_width(Beats);
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  stream_state_e             state_q;
  logic                      oldest_q;  // bank currently streaming / next to stream
  logic [CntW-1:0]           beat_q;
  logic [FRAME_ID_WIDTH-1:0] next_id_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic                      cap_rdy_q;
  logic [BeatW-1:0]          m_data_q;
  logic                      m_valid_q;
  logic                      m_sof_q;
  logic                      m_eof_q;
  logic [FRAME_ID_WIDTH-1:0] m_id_q;

  logic [1:0]                bank_valid;
  logic [1:0]                bank_wr;
  logic [1:0]                bank_clr;
  logic [1:0]                valid_after;
  logic [BeatW-1:0]          bank_rd [2];
  logic [FRAME_ID_WIDTH-1:0] bank_id [2];

  logic                      hs;
  logic                      last_hs;
  logic                      cap_ok;
  logic                      cap_sel;
  logic                      load;
  logic                      go_idle;
  logic                      from_input;
  logic                      nxt_bank;
  logic [CntW-1:0]           nxt_beat;
  logic [BeatW-1:0]          nxt_data;
  logic [FRAME_ID_WIDTH-1:0] nxt_id;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    result_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .NUM_WORDS     (NUM_WORDS),
      .LANES         (LANES),
      .FRAME_ID_WIDTH(FRAME_ID_WIDTH),
      .CNT_WIDTH     (CntW)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (bank_wr[b]),
      .wr_data_i(result_data_i),
      .wr_id_i  (next_id_q),
      .clr_i    (bank_clr[b]),
      .rd_beat_i(nxt_beat),
      .rd_data_o(bank_rd[b]),
      .valid_o  (bank_valid[b]),
      .id_o     (bank_id[b])
    );
  end

  // Allocation: the draining bank stays busy through its eof handshake, so a
  // capture in that cycle only sees the other bank.
  always_comb begin
    hs          = m_valid_q & m_if.m_ready;
    last_hs     = hs & m_eof_q;
    cap_sel     = bank_valid[0];
    cap_ok      = result_valid_i & ~(&bank_valid);
    bank_wr     = 2'b00;
    bank_clr    = 2'b00;
    if (cap_ok) begin
      bank_wr = cap_sel ? 2'b10 : 2'b01;
    end
    if (last_hs) begin
      bank_clr = oldest_q ? 2'b10 : 2'b01;
    end
    valid_after = (bank_valid & ~bank_clr) | bank_wr;
  end

  // Next presented beat. A frame captured on this very edge has no stored copy
  // yet, so its first beat is taken straight from result_data_i.
  always_comb begin
    load       = 1'b0;
    go_idle    = 1'b0;
    from_input = 1'b0;
    nxt_bank   = oldest_q;
    nxt_beat   = '0;
    unique case (state_q)
      StIdle: begin
        if (cap_ok) begin
          load       = 1'b1;
          from_input = 1'b1;
          nxt_bank   = cap_sel;
        end
      end
      StStream: begin
        if (hs) begin
          load = 1'b1;
          if (!m_eof_q) begin
            nxt_beat = beat_q + CntW'(1);
          end else if (bank_valid[~oldest_q]) begin
            nxt_bank = ~oldest_q;
          end else if (bank_wr[~oldest_q]) begin
            nxt_bank   = ~oldest_q;
            from_input = 1'b1;
          end else begin
            load    = 1'b0;
            go_idle = 1'b1;
          end
        end
      end
      default: ;
    endcase
    nxt_data = from_input ? result_data_i[BeatW-1:0] : bank_rd[nxt_bank];
    nxt_id   = from_input ? next_id_q : bank_id[nxt_bank];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      oldest_q  <= 1'b0;
      beat_q    <= '0;
      next_id_q <= '0;
      drop_q    <= '0;
      cap_rdy_q <= 1'b1;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eof_q   <= 1'b0;
      m_id_q    <= '0;
    end else begin
      cap_rdy_q <= ~(&valid_after);
      if (cap_ok) begin
        next_id_q <= next_id_q + FRAME_ID_WIDTH'(1);
      end else if (result_valid_i && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_CNT_WIDTH'(1);
      end
      if (load) begin
        state_q   <= StStream;
        oldest_q  <= nxt_bank;
        beat_q    <= nxt_beat;
        m_valid_q <= 1'b1;
        m_data_q  <= nxt_data;
        m_sof_q   <= (nxt_beat == '0);
        m_eof_q   <= (nxt_beat == LastBeat);
        m_id_q    <= nxt_id;
      end else if (go_idle) begin
        state_q   <= StIdle;
        beat_q    <= '0;
        m_valid_q <= 1'b0;
        m_sof_q   <= 1'b0;
        m_eof_q   <= 1'b0;
      end
    end
  end

  assign capture_ready_o  = cap_rdy_q;
  assign frames_dropped_o = drop_q;
  assign m_if.m_data      = m_data_q;
  assign m_if.m_valid     = m_valid_q;
  assign m_if.m_sof       = m_sof_q;
  assign m_if.m_eof       = m_eof_q;
  assign m_if.m_frame_id  = m_id_q;

endmodule

// File: tb/tb_kan_tda_result_streamer.sv
// Scoreboard bench for kan_tda_result_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares every handshake and checks stall stability.
module tb_kan_tda_result_streamer;
  import kan_tda_stream_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned NW    = 256;
  localparam int unsigned LN    = 4;
  localparam int unsigned IDW   = 8;
  localparam int unsigned DCW   = 16;
  localparam int unsigned BW    = DW * LN;
  localparam int unsigned BEATS = BEATS_PER_FRAME;

  typedef struct packed {
    logic [BW-1:0]  data;
    logic           sof;
    logic           eof;
    logic [IDW-1:0] id;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NW*DW-1:0] result_data;
  logic             result_valid;
  logic             capture_ready;
  logic [DCW-1:0]   frames_dropped;

  kan_tda_result_streamer_if #(.DATA_W(BW), .ID_W(IDW)) m_if ();

  kan_tda_result_streamer #(
    .DATA_WIDTH    (DW),
    .NUM_WORDS     (NW),
    .LANES         (LN),
    .FRAME_ID_WIDTH(IDW),
    .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .result_data_i   (result_data),
    .result_valid_i  (result_valid),
    .capture_ready_o (capture_ready),
    .frames_dropped_o(frames_dropped),
    .m_if            (m_if.master)
  );

  initial forever #5 clk = ~clk;

  beat_t          exp_q[$];
  int             tests = 0;
  int             fails = 0;
  int             hs_total = 0;
  bit             rdy_rand = 1'b0;
  logic [BW-1:0]  sof_data, eof_data;
  logic [IDW-1:0] sof_id;
  logic           mon_stall = 1'b0;
  beat_t          mon_prev;

  function automatic logic [DW-1:0] word(int seed, int i);
    return {8'(seed), 8'(i)};
  endfunction

  function automatic logic [NW*DW-1:0] make_frame(int seed);
    logic [NW*DW-1:0] f;
    for (int i = 0; i < NW; i++) f[i*DW +: DW] = word(seed, i);
    return f;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int seed, input int id);
    beat_t b;
    for (int k = 0; k < BEATS; k++) begin
      for (int j = 0; j < LN; j++) b.data[j*DW +: DW] = word(seed, k*LN + j);
      b.sof = (k == 0);
      b.eof = (k == BEATS - 1);
      b.id  = IDW'(id);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse(input int seed);
    result_data  = make_frame(seed);
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    result_valid = 1'b0;
    rdy_rand     = 1'b0;
    m_if.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_if.m_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 80'((exp_q.size() == 0) && !m_if.m_valid), 80'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_eof(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_if.m_valid && m_if.m_eof && m_if.m_ready) && n < 500);
    check(name, 80'(m_if.m_valid && m_if.m_eof), 80'd1);
  endtask

  // Random sink readiness while rdy_rand is set.
  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) m_if.m_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        check("hold_valid", 80'(m_if.m_valid), 80'd1);
        check("hold_data", 80'(m_if.m_data), 80'(mon_prev.data));
        check("hold_ctl", 80'({m_if.m_sof, m_if.m_eof, m_if.m_frame_id}),
              80'({mon_prev.sof, mon_prev.eof, mon_prev.id}));
      end
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m_if.m_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 80'(m_if.m_data), 80'(e.data));
          check("beat_ctl", 80'({m_if.m_sof, m_if.m_eof, m_if.m_frame_id}),
                80'({e.sof, e.eof, e.id}));
        end
        hs_total++;
        if (m_if.m_sof) begin
          sof_data = m_if.m_data;
          sof_id   = m_if.m_frame_id;
        end
        if (m_if.m_eof) eof_data = m_if.m_data;
      end
      mon_stall = m_if.m_valid && !m_if.m_ready;
      mon_prev  = {m_if.m_data, m_if.m_sof, m_if.m_eof, m_if.m_frame_id};
    end
  end

  initial begin
    int cnt;
    int base;
    int n;
    result_data = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_valid", 80'(m_if.m_valid), 80'd0);
    check("rst_sof_eof", 80'({m_if.m_sof, m_if.m_eof}), 80'd0);
    check("rst_data", 80'(m_if.m_data), 80'd0);
    check("rst_id", 80'(m_if.m_frame_id), 80'd0);
    check("rst_drops", 80'(frames_dropped), 80'd0);
    check("rst_cap_ready", 80'(capture_ready), 80'd1);
    @(posedge clk); #1;

    // 1: single ramp frame, sink always ready.
    push_frame(0, 0);
    pulse(0);
    cnt = 0;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      if (k == 0) check("t1_latency", 80'({m_if.m_valid, m_if.m_sof}), 80'b11);
      if (m_if.m_valid && m_if.m_ready) cnt++;
    end
    check("t1_consecutive", 80'(cnt), 80'(BEATS));
    @(negedge clk);
    check("t1_idle_after", 80'(m_if.m_valid), 80'd0);
    check("t1_cap_ready", 80'(capture_ready), 80'd1);
    check("t1_beat0", 80'(sof_data), 80'h0003000200010000);
    check("t1_beat63", 80'(eof_data), 80'h00FF00FE00FD00FC);
    check("t1_id", 80'(sof_id), 80'd0);
    check("t1_empty", 80'(exp_q.size()), 80'd0);
    @(posedge clk); #1;

    // 2: random backpressure on a ramp frame.
    do_reset();
    rdy_rand = 1'b1;
    push_frame(0, 0);
    pulse(0);
    wait_drain("t2_drain", 2000);
    rdy_rand = 1'b0;
    m_if.m_ready = 1'b1;

    // 3: sink stalled, three pulses two cycles apart, third dropped.
    do_reset();
    m_if.m_ready = 1'b0;
    push_frame(1, 0);
    pulse(1);
    check("t3_ready_one", 80'(capture_ready), 80'd1);
    @(posedge clk); #1;
    push_frame(2, 1);
    pulse(2);
    check("t3_ready_two", 80'(capture_ready), 80'd0);
    @(posedge clk); #1;
    pulse(3);
    check("t3_drops", 80'(frames_dropped), 80'd1);
    check("t3_ready_full", 80'(capture_ready), 80'd0);
    m_if.m_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 2 * BEATS; k++) begin
      @(negedge clk);
      if (m_if.m_valid) cnt++;
    end
    check("t3_no_gap", 80'(cnt), 80'(2 * BEATS));
    @(negedge clk);
    check("t3_idle_after", 80'(m_if.m_valid), 80'd0);
    check("t3_empty", 80'(exp_q.size()), 80'd0);
    @(posedge clk); #1;

    // 4a: capture on eof handshake with the other bank busy -> dropped.
    do_reset();
    m_if.m_ready = 1'b0;
    push_frame(4, 0);
    pulse(4);
    @(posedge clk); #1;
    push_frame(5, 1);
    pulse(5);
    m_if.m_ready = 1'b1;
    wait_eof("t4a_eof");
    result_data  = make_frame(6);
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    check("t4a_drops", 80'(frames_dropped), 80'd1);
    wait_drain("t4a_drain", 400);

    // 4b: capture on eof handshake with the other bank free -> streams at once.
    do_reset();
    push_frame(7, 0);
    pulse(7);
    wait_eof("t4b_eof");
    push_frame(8, 1);
    result_data  = make_frame(8);
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    @(negedge clk);
    check("t4b_no_bubble", 80'({m_if.m_valid, m_if.m_sof, m_if.m_frame_id}),
          80'({1'b1, 1'b1, 8'd1}));
    check("t4b_drops", 80'(frames_dropped), 80'd0);
    wait_drain("t4b_drain", 400);

    // 5: reset at beat 30 with a second frame buffered and one drop counted.
    do_reset();
    base = hs_total;
    push_frame(9, 0);
    pulse(9);
    push_frame(10, 1);
    pulse(10);
    pulse(11);
    check("t5_drops_pre", 80'(frames_dropped), 80'd1);
    n = 0;
    while ((hs_total - base) < 30 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_reached_beat30", 80'(hs_total - base), 80'd30);
    m_if.m_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_valid", 80'(m_if.m_valid), 80'd0);
    check("t5_cap_ready", 80'(capture_ready), 80'd1);
    check("t5_drops", 80'(frames_dropped), 80'd0);
    @(posedge clk); #1;
    m_if.m_ready = 1'b1;
    push_frame(12, 0);
    pulse(12);
    wait_drain("t5_drain", 400);
    check("t5_new_id", 80'(sof_id), 80'd0);

    // 6: 257 frames, frame id wraps 255 -> 0.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      n = 0;
      while (!capture_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("t6_cap_ready_wait", 80'(capture_ready), 80'd1);
      push_frame(i % 256, i % 256);
      pulse(i % 256);
    end
    wait_drain("t6_drain", 1000);
    check("t6_wrap_id", 80'(sof_id), 80'd0);
    check("t6_drops", 80'(frames_dropped), 80'd0);

    // 7: drop counter saturation with both banks held busy.
    do_reset();
    m_if.m_ready = 1'b0;
    pulse(13);
    pulse(14);
    result_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("t7_drops_100", 80'(frames_dropped), 80'd100);
    repeat (65535) @(posedge clk);
    #1;
    check("t7_drops_sat", 80'(frames_dropped), 80'hFFFF);
    @(posedge clk); #1;
    check("t7_drops_hold", 80'(frames_dropped), 80'hFFFF);
    check("t7_cap_ready", 80'(capture_ready), 80'd0);
    result_valid = 1'b0;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kan_tda_result_streamer.md
Name: kan_tda_result_streamer

Overview:
Downstream stage of the KAN/TDA compute core. Captures the 256-word result bank whenever the core pulses result_valid. Buffers up to two frames in ping-pong banks. Drains each frame as a valid/ready stream of 64-bit beats toward the host/DMA interface, with frame markers and drop accounting.

Parameters:
DATA_WIDTH, 16, bits per result word
NUM_WORDS, 256, words per result frame
LANES, 4, words per output beat; stream width = LANES*DATA_WIDTH
FRAME_ID_WIDTH, 8, width of frame sequence number
DROP_CNT_WIDTH, 16, width of saturating drop counter

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
result_data  in  NUM_WORDS*DATA_WIDTH  flattened result bank; word i at [i*DATA_WIDTH +: DATA_WIDTH]
result_valid  in  1  single-cycle frame-available strobe from core
capture_ready  out  1  registered; high when at least one bank is free
m_data  out  LANES*DATA_WIDTH  beat payload
m_valid  out  1  beat valid
m_ready  in  1  sink ready
m_sof  out  1  high on first beat of a frame
m_eof  out  1  high on last beat of a frame
m_frame_id  out  FRAME_ID_WIDTH  sequence number of the frame being streamed
frames_dropped  out  DROP_CNT_WIDTH  saturating count of rejected frames

Behaviour:
- Reset (rst high at a clk edge):
  - m_valid, m_sof and m_eof = 0.
  - m_data, m_frame_id and frames_dropped = 0.
  - capture_ready = 1.
  - Both banks free; beat counter 0; next frame id 0; state IDLE.
- Reset mid-frame: the frame is abandoned with no eof. Buffered frames are discarded.
- Capture:
  - On a clk edge with result_valid=1, if a bank is free, the whole result_data is copied into it in one cycle.
  - The frame is tagged with the next frame id, which then increments modulo 2^FRAME_ID_WIDTH.
  - If both banks are free, bank 0 is chosen.
  - If no bank is free, the frame is dropped:
    - frames_dropped increments and saturates at all-ones.
    - The frame id does not advance.
- Bank free rule:
  - A bank becomes free on the edge after its last beat handshakes.
  - In the cycle the last beat is accepted, that bank still counts as busy. A simultaneous result_valid uses the other bank if it is free, otherwise it is dropped.
- capture_ready reflects the bank state after the current edge's capture and free updates.
- Frames stream in capture order (oldest first).
- State machine:
  - IDLE -> STREAM when a bank is pending.
    - m_valid rises on the edge after capture, giving 1-cycle latency from result_valid to the first m_valid.
  - STREAM: beat k (0..NUM_WORDS/LANES-1) carries word k*LANES+j in lane j, at [j*DATA_WIDTH +: DATA_WIDTH].
  - A beat advances only when m_valid and m_ready are both high.
  - m_sof = (k==0); m_eof = (k==last).
  - After the eof handshake:
    - If another frame is pending, its first beat is presented on the next cycle (no bubble).
    - Otherwise the state returns to IDLE and m_valid drops.
- Stream rules:
  - While m_valid=1 and m_ready=0, m_data, m_sof, m_eof and m_frame_id hold stable.
  - m_valid never deasserts without a handshake, except on rst.
- NUM_WORDS must be a multiple of LANES. Beats per frame = NUM_WORDS/LANES (64 at defaults).
- Beat counter width = clog2(beats per frame). It wraps to 0 at eof.

Decomposition:
- Package kan_tda_stream_pkg holds:
  - BEATS_PER_FRAME and BEAT_CNT_WIDTH derivation.
  - The state enum (IDLE, STREAM).
  - The lane-packing constants.
- Sub-module result_bank, instantiated twice:
  - One-cycle full-frame write port.
  - Beat-indexed read port returning LANES words.
  - Valid flag plus frame-id tag.
- The top level holds:
  - Allocation and order FIFO: a 1-bit "oldest bank" pointer.
  - Streaming FSM.
  - Drop counter.

Test Plan:
- Single frame, word i = i, m_ready=1:
  - 64 beats on consecutive cycles starting 1 cycle after result_valid.
  - Beat 0 = 0x0003000200010000 with m_sof=1; beat 63 = 0x00FF00FE00FD00FC with m_eof=1.
  - m_frame_id=0; capture_ready returns to 1 after eof.
- Random m_ready (50%) on a ramp frame: payload sequence identical to the above, and outputs held stable during every stall cycle (scoreboard plus stability check).
- m_ready=0, three result_valid pulses 2 cycles apart:
  - First two captured (ids 0 and 1), third dropped.
  - frames_dropped=1; capture_ready=0 after the second capture.
  - After release, 128 beats stream: frame 0 then frame 1, no gap at the boundary.
- result_valid in the same cycle as the eof handshake of frame A, with the other bank busy: the new frame is dropped (frames_dropped+1). Repeat with the other bank free: the new frame is captured and streams immediately after A.
- rst asserted at beat 30 of a frame, with a second frame buffered:
  - Next cycle m_valid=0, capture_ready=1, frames_dropped=0.
  - The next captured frame gets m_frame_id=0.
- 257 frames with m_ready=1: m_frame_id wraps 255 -> 0. Separately, force drops to 0xFFFF and the counter stays at 0xFFFF.
